// File: rtl/demux1x2_stream.sv
// demux1x2_stream: registered 1-to-2 stream demultiplexer
// one-entry buffer and word counter per output

module demux1x2_stream #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             rr_ptr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic tgt;
  logic free0;
  logic free1;
  logic push;
  logic push0;
  logic push1;
  logic pop0;
  logic pop1;

  // target select, buffer-free flags and handshake decode
  always_comb begin
    tgt      = (MODE == 0) ? in_sel : rr_ptr;
    free0    = !out0_valid | out0_ready;
    free1    = !out1_valid | out1_ready;
    in_ready = tgt ? free1 : free0;
    push     = in_valid & in_ready;
    push0    = push & !tgt;
    push1    = push & tgt;
    pop0     = out0_valid & out0_ready;
    pop1     = out1_valid & out1_ready;
  end

  // output buffer 0: replace on push, empty on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_data  <= '0;
      out0_valid <= 1'b0;
    end else if (push0) begin
      out0_data  <= in_data;
      out0_valid <= 1'b1;
    end else if (pop0) begin
      out0_valid <= 1'b0;
    end
  end

  // output buffer 1: replace on push, empty on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_data  <= '0;
      out1_valid <= 1'b0;
    end else if (push1) begin
      out1_data  <= in_data;
      out1_valid <= 1'b1;
    end else if (pop1) begin
      out1_valid <= 1'b0;
    end
  end

  // round-robin pointer advances per accepted word (stays 0 when steering by in_sel)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if ((MODE != 0) && push) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  // wrapping per-output accepted-word counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) cnt0 <= cnt0 + 1'b1;
      if (push1) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule
